// File: rtl/zle_pkg.sv
// Shared encodings for the zero run-length encoder.
// Token kinds and FSM state names.
package zle_pkg;

  localparam logic [1:0] KIND_LIT = 2'd0;
  localparam logic [1:0] KIND_RUN = 2'd1;
  localparam logic [1:0] KIND_EOS = 2'd2;

  typedef enum logic {
    ST_START = 1'b0,
    ST_ZEROS = 1'b1
  } state_t;

endpackage

// File: rtl/zle_slot.sv
// One-entry valid/data register with load and clear.
// Load wins over clear.
module zle_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v <= 1'b0;
      q <= '0;
    end else if (load) begin
      v <= 1'b1;
      q <= d;
    end else if (clear) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/zle_param_enc.sv
// Parametrised zero run-length encoder, valid/ready in and out.
// Literals pass, zero runs collapse to run tokens, EOS flushes.
module zle_param_enc
  import zle_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_eos,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [1:0]    o_kind,
  output logic [DW-1:0] o_data
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state, st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            h_v, h_e, h_done;
  logic [DW-1:0]   h_d;
  logic            accept, free, z;
  logic            emit;
  logic [1:0]      e_kind;
  logic [DW-1:0]   e_data;

  assign i_ready = !h_v | h_done;
  assign accept  = i_valid & i_ready;
  assign free    = !o_valid | o_ready;
  assign z       = !h_e && (h_d == '0);

  zle_slot #(.W(DW+1)) u_hist (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .clear (h_done),
    .d     ({i_eos, i_data}),
    .v     (h_v),
    .q     ({h_e, h_d})
  );

  zle_slot #(.W(DW+2)) u_out (
    .clock (clock),
    .reset (reset),
    .load  (emit),
    .clear (o_ready),
    .d     ({e_kind, e_data}),
    .v     (o_valid),
    .q     ({o_kind, o_data})
  );

  always_comb begin
    h_done = 1'b0;
    emit   = 1'b0;
    e_kind = KIND_LIT;
    e_data = '0;
    cnt_n  = cnt;
    st_n   = state;
    if (h_v) begin
      unique case (state)
        ST_START: begin
          if (z) begin
            h_done = 1'b1;
            cnt_n  = CW'(1);
            st_n   = ST_ZEROS;
          end else if (free) begin
            emit   = 1'b1;
            h_done = 1'b1;
            e_kind = h_e ? KIND_EOS : KIND_LIT;
            e_data = h_e ? '0 : h_d;
          end
        end
        ST_ZEROS: begin
          if (z && cnt != CNT_MAX) begin
            h_done = 1'b1;
            cnt_n  = cnt + CW'(1);
          end else if (free) begin
            // A non-zero token stays held and is re-seen in START.
            emit   = 1'b1;
            e_kind = KIND_RUN;
            e_data = DW'(cnt);
            h_done = z;
            cnt_n  = z ? CW'(1) : '0;
            st_n   = z ? ST_ZEROS : ST_START;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_START;
      cnt   <= '0;
    end else begin
      state <= st_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_zle_param_enc.sv
// Bench for zle_param_enc: directed cases plus a random stream
// compared against a token-level run-length model.
module tb_zle_param_enc;
  import zle_pkg::*;

  typedef struct packed {
    logic       e;
    logic [7:0] d;
  } tok_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_data;
  logic       i_eos;
  logic       o_valid;
  logic       o_ready;
  logic [1:0] o_kind;
  logic [7:0] o_data;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  logic rdy_s;

  tok_t       tin[$];
  logic [9:0] expq[$];
  logic [9:0] got[$];

  always #5 clock = ~clock;

  zle_param_enc #(.DW(8), .CW(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_eos   (i_eos),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_kind  (o_kind),
    .o_data  (o_data)
  );

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, g, e);
    end
  endtask

  always begin
    @(negedge clock);
    #4;
    if (!reset && o_valid && o_ready) begin
      got.push_back({o_kind, o_data});
      chk("legal_token",
          32'(o_kind != 2'd3 &&
              !(o_kind == 2'd1 && (o_data == 0 || o_data > 15))),
          32'd1);
    end
  end

  // One cycle: drive o_ready, sample i_ready before the edge.
  task automatic step();
    case (mode)
      0: o_ready = 1'b1;
      1: o_ready = ($urandom % 4) != 0;
      default: o_ready = 1'b0;
    endcase
    #4;
    rdy_s = i_ready;
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    int n = 0;
    logic acc = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_eos   = e;
    while (!acc && n < 200) begin
      step();
      acc = rdy_s;
      n++;
    end
    i_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    else tin.push_back('{e: e, d: d});
  endtask

  // Reference: walk the token list, counting zero runs.
  task automatic build_exp();
    int run = 0;
    expq.delete();
    foreach (tin[i]) begin
      if (!tin[i].e && tin[i].d == 0) begin
        if (run == 15) begin
          expq.push_back({2'd1, 8'd15});
          run = 1;
        end else run++;
      end else begin
        if (run > 0) expq.push_back({2'd1, 8'(run)});
        run = 0;
        if (tin[i].e) expq.push_back({2'd2, 8'd0});
        else expq.push_back({2'd0, tin[i].d});
      end
    end
  endtask

  task automatic check_stream(input string tag);
    int n = 0;
    build_exp();
    while (got.size() < expq.size() && n < 400) begin
      step();
      n++;
    end
    repeat (4) step();
    chk({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk({tag, "_tok"}, 32'(got[i]), 32'(expq[i]));
    tin.delete();
    got.delete();
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_eos   = 1'b0;
    o_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_kind", 32'(o_kind), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("rst_i_ready", 32'(rdy_s), 32'd1);

    // 1: literal latency, then a short run.
    send(8'd5, 1'b0);
    #4;
    chk("lat_early", 32'(o_valid), 32'd0);
    @(negedge clock);
    #4;
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat_data", 32'({o_kind, o_data}), 32'({2'd0, 8'd5}));
    @(negedge clock);
    for (int i = 0; i < 3; i++) send(8'd0, 1'b0);
    send(8'd7, 1'b0);
    check_stream("t1");

    // 2: run longer than the counter.
    for (int i = 0; i < 17; i++) send(8'd0, 1'b0);
    send(8'd9, 1'b0);
    check_stream("t2");

    // 3: exactly one full run then EOS.
    for (int i = 0; i < 15; i++) send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    check_stream("t3");

    // 4: EOS flushes a run.
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    send(8'd3, 1'b0);
    check_stream("t4");
    chk("t4_cnt", 32'(dut.cnt), 32'd0);
    chk("t4_state", 32'(dut.state), 32'(ST_START));

    // 5: output stall backs up the input.
    mode = 2;
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    i_valid = 1'b1;
    i_data  = 8'd5;
    i_eos   = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rdy_s) seen++;
    end
    chk("t5_stalled", 32'(seen), 32'd0);
    chk("t5_frozen", 32'({o_valid, o_kind, o_data}),
        32'({1'b1, 2'd0, 8'd3}));
    mode = 0;
    send(8'd5, 1'b0);
    send(8'd6, 1'b0);
    check_stream("t5");

    // 6: reset mid-run drops the pending count.
    for (int i = 0; i < 6; i++) send(8'd0, 1'b0);
    step();
    chk("t6_cnt", 32'(dut.cnt), 32'd6);
    reset = 1'b1;
    #1;
    chk("t6_o_valid", 32'(o_valid), 32'd0);
    chk("t6_no_out", 32'(got.size()), 32'd0);
    tin.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    send(8'd0, 1'b0);
    send(8'd4, 1'b0);
    check_stream("t6");

    // Random stream with random backpressure.
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      int r = int'($urandom % 20);
      if (r == 0) begin
        for (int k = 0; k < 20; k++) send(8'd0, 1'b0);
      end else if (r < 10) send(8'd0, 1'b0);
      else if (r == 10) send(8'd0, 1'b1);
      else send(8'($urandom_range(1, 255)), 1'b0);
    end
    send(8'd1, 1'b0);
    check_stream("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
